// File: rtl/pfa_pkg.sv
// Shared types and sizing helpers for the pipelined P/G adder.
package pfa_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_STAGES = 4;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } pfa_op_e;

   typedef struct packed {
      logic cout;
      logic ovf;
   } pfa_flags_t;

   function automatic int slice_width(input int width, input int stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/pfa_slice.sv
// One SW-bit slice of the generate/propagate ripple adder.
module pfa_slice #(
   parameter int SW = 8
) (
   input  logic [SW-1:0] a,
   input  logic [SW-1:0] b,
   input  logic          cin,
   output logic [SW-1:0] sum,
   output logic          cout,
   output logic          c_msb
);

   logic [SW-1:0] g;
   logic [SW-1:0] p;
   logic [SW:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   always_comb begin
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < SW; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
   end

   assign sum   = p ^ c[SW-1:0];
   assign cout  = c[SW];
   assign c_msb = c[SW-1];

endmodule

// File: rtl/pfa_pipe_adder.sv
// Pipelined add/subtract: one SW-bit slice resolved per register stage, with
// valid/ready handshake and a single global advance shared by every stage.
module pfa_pipe_adder
   import pfa_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int SW = slice_width(WIDTH, STAGES);

   pfa_op_e          op;
   logic [WIDTH-1:0] b_eff;
   logic             c0;
   logic             advance;
   pfa_flags_t       flags;

   // Operand registers are kept right-shifted so each stage always consumes bits [SW-1:0].
   logic             vld_p   [STAGES];
   logic [WIDTH-1:0] a_p     [STAGES];
   logic [WIDTH-1:0] b_p     [STAGES];
   logic [WIDTH-1:0] sum_p   [STAGES];
   logic             carry_p [STAGES];
   logic             cmsb_p  [STAGES];

   assign op    = in_sub ? OP_SUB : OP_ADD;
   assign b_eff = (op == OP_SUB) ? ~in_b : in_b;
   assign c0    = (op == OP_SUB) ? 1'b1 : in_cin;

   assign advance  = !vld_p[STAGES-1] || out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam bit IS_LAST = (k == STAGES - 1);

      logic [WIDTH-1:0] a_src;
      logic [WIDTH-1:0] b_src;
      logic [WIDTH-1:0] sum_base;
      logic             c_src;
      logic             v_src;
      logic [SW-1:0]    s_sum;
      logic             s_cout;
      logic             s_cmsb;

      if (k == 0) begin : g_first
         assign a_src    = in_a;
         assign b_src    = b_eff;
         assign sum_base = '0;
         assign c_src    = c0;
         assign v_src    = in_valid;
      end else begin : g_next
         assign a_src    = a_p[k-1];
         assign b_src    = b_p[k-1];
         assign sum_base = sum_p[k-1];
         assign c_src    = carry_p[k-1];
         assign v_src    = vld_p[k-1];
      end

      pfa_slice #(.SW(SW)) u_slice (
         .a     (a_src[SW-1:0]),
         .b     (b_src[SW-1:0]),
         .cin   (c_src),
         .sum   (s_sum),
         .cout  (s_cout),
         .c_msb (s_cmsb)
      );

      // ---- stage k register boundary ----
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_p[k] <= 1'b0;
         end else if (advance) begin
            vld_p[k] <= v_src;
         end
      end

      always_ff @(posedge clk) begin
         if (rst && IS_LAST) begin
            sum_p[k]   <= '0;
            carry_p[k] <= 1'b0;
            cmsb_p[k]  <= 1'b0;
         end else if (advance && v_src) begin
            a_p[k]     <= a_src >> SW;
            b_p[k]     <= b_src >> SW;
            sum_p[k]   <= sum_base | (WIDTH'(s_sum) << (k * SW));
            carry_p[k] <= s_cout;
            cmsb_p[k]  <= s_cmsb;
         end
      end
   end

   assign flags.cout = carry_p[STAGES-1];
   assign flags.ovf  = carry_p[STAGES-1] ^ cmsb_p[STAGES-1];

   assign out_valid = vld_p[STAGES-1];
   assign out_sum   = sum_p[STAGES-1];
   assign out_cout  = flags.cout;
   assign out_ovf   = flags.ovf;

endmodule

// File: tb/tb_pfa_pipe_adder.sv
// Scoreboard bench for pfa_pipe_adder: directed/backpressure/reset checks at
// 32x4 plus random sweeps at 8x1, 16x2 and 64x8.
module tb_pfa_pipe_adder;

   logic        clk = 1'b0;
   int unsigned cyc = 0;
   int          n_vec = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int cfg_w(input int i);
      case (i)
         0:       return 32;
         1:       return 8;
         2:       return 16;
         default: return 64;
      endcase
   endfunction

   function automatic int cfg_s(input int i);
      case (i)
         0:       return 4;
         1:       return 1;
         2:       return 2;
         default: return 8;
      endcase
   endfunction

   task automatic chk(input string nm, input int cfg, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cfg%0d: got %h, want %h (t=%0t)", nm, cfg, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 4; g++) begin : g_cfg
      localparam int W = cfg_w(g);
      localparam int S = cfg_s(g);

      typedef struct packed {
         logic [W-1:0] sum;
         logic         cout;
         logic         ovf;
         logic         chk_lat;
         logic [31:0]  acc;
      } exp_t;

      logic         rst, in_valid, in_ready, in_cin, in_sub;
      logic         out_valid, out_ready, out_cout, out_ovf;
      logic [W-1:0] in_a, in_b, out_sum;
      exp_t         q[$];
      exp_t         me;
      bit           bp_en = 1'b0;
      bit           fin = 1'b0;
      bit           stall_prev = 1'b0;
      logic [W-1:0] snap_sum;
      logic [2:0]   snap_fl;

      pfa_pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .in_a      (in_a),
         .in_b      (in_b),
         .in_cin    (in_cin),
         .in_sub    (in_sub),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .out_sum   (out_sum),
         .out_cout  (out_cout),
         .out_ovf   (out_ovf)
      );

      // Downstream ready: steady 1, or the 1,0,0,1 backpressure pattern.
      always @(negedge clk) begin
         out_ready = bp_en ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      end

      function automatic exp_t mk(input logic [W-1:0] s, input logic co, input logic ov, input logic lat);
         exp_t e;
         e.sum = s; e.cout = co; e.ovf = ov; e.chk_lat = lat; e.acc = '0;
         return e;
      endfunction

      // Reference: full-width add, overflow from operand/result sign agreement.
      function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin, input logic sub, input logic lat);
         logic [W-1:0] bb;
         logic [W:0]   t;
         logic         ov;
         bb = sub ? ~b : b;
         t  = {1'b0, a} + {1'b0, bb} + (W+1)'(sub ? 1'b1 : cin);
         ov = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
         return mk(t[W-1:0], t[W], ov, lat);
      endfunction

      task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub, input exp_t e);
         in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
         for (int t = 0; t < 64; t++) begin
            #1;
            if (in_ready === 1'b1) begin
               e.acc = cyc + 1;
               q.push_back(e);
               @(negedge clk);
               return;
            end
            @(negedge clk);
         end
         chk("accept_timeout", g, 64'(0), 64'(1));
      endtask

      task automatic drain();
         in_valid = 1'b0;
         for (int t = 0; t < 400; t++) begin
            #3;
            if (q.size() == 0 && out_valid !== 1'b1) begin
               @(negedge clk);
               return;
            end
            @(negedge clk);
         end
         chk("drain_timeout", g, 64'(q.size()), 64'(0));
      endtask

      task automatic do_reset();
         rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
         repeat (3) @(negedge clk);
         rst = 1'b0;
      endtask

      always @(negedge clk) begin
         #2;
         if (rst !== 1'b0) begin
            stall_prev = 1'b0;
         end else begin
            chk("in_ready_rule", g, 64'(in_ready), 64'(!out_valid || out_ready));
            if (stall_prev) begin
               chk("stall_hold_sum", g, 64'(out_sum), 64'(snap_sum));
               chk("stall_hold_flags", g, 64'({out_valid, out_cout, out_ovf}), 64'(snap_fl));
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
               if (q.size() == 0) begin
                  chk("unexpected_beat", g, 64'(out_sum), 64'(0));
               end else begin
                  me = q.pop_front();
                  chk("sum", g, 64'(out_sum), 64'(me.sum));
                  chk("cout", g, 64'(out_cout), 64'(me.cout));
                  chk("ovf", g, 64'(out_ovf), 64'(me.ovf));
                  if (me.chk_lat) chk("latency", g, 64'(cyc - me.acc), 64'(S - 1));
               end
            end
            stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
            snap_sum   = out_sum;
            snap_fl    = {out_valid, out_cout, out_ovf};
         end
      end

      if (g == 0) begin : g_dir
         initial begin
            do_reset();
            #1;
            chk("rst_out_valid", g, 64'(out_valid), 64'(0));
            chk("rst_out_sum", g, 64'(out_sum), 64'(0));
            chk("rst_out_flags", g, 64'({out_cout, out_ovf}), 64'(0));
            chk("rst_in_ready", g, 64'(in_ready), 64'(1));
            @(negedge clk);

            issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
            issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b1));
            issue(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, mk(32'h0001_0000, 1'b0, 1'b0, 1'b1));
            issue(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1));
            issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1));
            issue(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1));
            issue(32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
            drain();

            bp_en = 1'b1;
            for (int i = 0; i < 16; i++) begin
               logic [W-1:0] a, b;
               logic         c, s;
               a = W'($urandom); b = W'($urandom); c = 1'($urandom); s = 1'($urandom);
               issue(a, b, c, s, model(a, b, c, s, 1'b0));
            end
            drain();
            bp_en = 1'b0;
            @(negedge clk);

            issue(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0, mk(32'h0000_0033, 1'b0, 1'b0, 1'b0));
            issue(32'h0000_0044, 32'h0000_0055, 1'b0, 1'b0, mk(32'h0000_0099, 1'b0, 1'b0, 1'b0));
            issue(32'h0000_0066, 32'h0000_0077, 1'b0, 1'b0, mk(32'h0000_00DD, 1'b0, 1'b0, 1'b0));
            rst = 1'b1; in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678;
            q.delete();
            @(negedge clk);
            rst = 1'b0; in_valid = 1'b0;
            #1;
            chk("midrst_out_valid", g, 64'(out_valid), 64'(0));
            issue(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, mk(32'h0000_0003, 1'b0, 1'b0, 1'b1));
            drain();
            fin = 1'b1;
         end
      end else begin : g_rnd
         initial begin
            do_reset();
            @(negedge clk);
            for (int i = 0; i < 1000; i++) begin
               logic [63:0]  r1, r2;
               logic [W-1:0] a, b;
               logic         c, s;
               r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom};
               a = r1[W-1:0]; b = r2[W-1:0]; c = 1'($urandom); s = 1'($urandom);
               issue(a, b, c, s, model(a, b, c, s, 1'b1));
            end
            drain();
            fin = 1'b1;
         end
      end
   end

   initial begin
      int t;
      t = 0;
      while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20000) chk("global_timeout", -1, 64'(0), 64'(1));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pfa_pipe_adder.md
Name: pfa_pipe_adder

Overview:
Parametrised, pipelined successor to the team's 32-bit ripple generate/propagate adder.
- Splits a WIDTH-bit add/subtract into STAGES equal slices, one slice per register stage.
- Adds carry-in, carry-out, a signed-overflow flag, an add/sub mode, and a valid/ready handshake on both sides.
- Sits in the datapath as a drop-in arithmetic unit for streaming operands, at full throughput.

Parameters:
WIDTH, 32, operand and sum width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline register stages; slice width SW = WIDTH/STAGES; 1 <= STAGES <= WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in; ignored when in_sub=1
in_sub  input  1  0: A+B+cin; 1: A-B, computed as A+~B+1
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
out_sum  output  WIDTH  result
out_cout  output  1  carry out of the MSB; in sub mode 1 means no borrow
out_ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- The only clock is clk. Reset is synchronous and active-high on rst.
- Reset clears every stage valid bit, out_sum, out_cout and out_ovf to 0. in_ready is 1 in the first cycle after reset.
- Per-slice arithmetic uses the team's P/G ripple:
  - G = a&b, P = a^b.
  - c[i+1] = G[i] | (P[i] & c[i]).
  - s = P ^ c.
- Operand B' = in_sub ? ~in_b : in_b. Carry into slice 0 = in_sub ? 1 : in_cin.
- Stage k (k = 0..STAGES-1) register holds:
  - valid bit
  - sum slices 0..k (computed)
  - A and B' slices k+1..STAGES-1 (not yet consumed)
  - carry out of slice k
  - carry into the MSB (only meaningful once slice STAGES-1 is computed)
- Stage k computes slice k from its upper operand slices and the stage k-1 carry. Stage 0 computes from the input port directly.
- Global advance = !out_valid || out_ready. All stage registers load only when advance=1. in_ready = advance (combinational).
- A beat is accepted on edge n when in_valid && in_ready. Stage 0 captures it at edge n.
- With no stall, out_valid rises at edge n+STAGES-1; STAGES=1 therefore gives a registered result at edge n.
- Throughput is one beat per cycle.
- Bubbles (in_valid=0 while advancing) propagate as valid=0 entries and are not collapsed.
- Stall (out_valid && !out_ready): every stage holds, including invalid ones. out_* stay stable; in_ready=0.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- Final stage drives out_sum, out_cout = carry out of slice STAGES-1, and out_ovf.
- out_sum, out_cout and out_ovf are don't-care while out_valid=0, but must hold their last value (no X after reset).
- Arithmetic is modulo 2^WIDTH; the carry is reported only through out_cout.
- Reset asserted mid-operation discards all in-flight beats. out_valid=0 from the next edge; a beat offered that same cycle is not accepted.
- Simultaneous out accept and in accept on one edge is legal and sustains full rate.

Decomposition:
- Package pfa_pkg:
  - function slice_width(WIDTH, STAGES)
  - localparam default WIDTH and STAGES
  - typedef for the op mode: enum {OP_ADD, OP_SUB}
  - packed struct for the per-beat result flags (cout, ovf)
- Sub-module pfa_slice, combinational, parameter SW:
  - inputs: a, b, cin
  - outputs: sum, cout, c_msb (carry into the top bit)
  - implements the P/G ripple
  - instantiated once per stage in a generate loop
- Top-level holds only pipeline registers and handshake logic.

Test Plan:
- Add carry chain (WIDTH=32, STAGES=4): A=0xFFFFFFFF, B=0x00000001, cin=0, sub=0 -> sum=0x00000000, cout=1, ovf=0; out_valid exactly 3 edges after the accept edge.
- Signed overflow add: A=0x7FFFFFFF, B=0x00000001 -> sum=0x80000000, cout=0, ovf=1. Carry-in path: A=0x0000FFFF, B=0, cin=1 -> sum=0x00010000, cout=0.
- Subtract: A=5, B=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0. Subtract overflow: A=0x80000000, B=1, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Streaming with backpressure: 16 random beats, in_valid always 1, out_ready toggling 1,0,0,1 pattern -> all 16 results match the reference model in order; outputs stable while stalled; in_ready==(!out_valid||out_ready) every cycle.
- Reset mid-flight: accept 3 beats, assert rst for one cycle -> out_valid=0 after that edge, no stale beat ever emitted; the next accepted beat 0x1+0x2 -> sum=0x3.
- Parameter sweep: (WIDTH,STAGES) = (8,1), (16,2), (64,8) with 1000 random add/sub beats each -> bit-exact match on sum, cout and ovf; latency STAGES-1 edges after accept.
